// File: rtl/led_pattern_pkg.sv
// Shared phase encoding and pattern constants for the 16-LED pattern generator and its checker.
package led_pattern_pkg;

   localparam int LED_W = 16;

   typedef enum logic [2:0] {
      HUNT   = 3'd0,
      ALL_ON = 3'd1,
      FLASH  = 3'd2,
      SHIFT  = 3'd3,
      EXPAND = 3'd4,
      GAP    = 3'd5
   } phase_t;

   localparam logic [LED_W-1:0] PAT_ALL   = 16'hFFFF;
   localparam logic [LED_W-1:0] PAT_FLASH = 16'hAAAA;
   localparam logic [LED_W-1:0] PAT_SEED  = 16'h0180;
   localparam logic [LED_W-1:0] PAT_ZERO  = 16'h0000;

   // dir = 1 moves the pattern toward the MSB.
   function automatic logic [LED_W-1:0] shift_step(input logic [LED_W-1:0] p, input logic d);
      return d ? (p << 1) : (p >> 1);
   endfunction

   // Both halves move outward (grow) or inward (shrink) from the centre pair.
   function automatic logic [LED_W-1:0] expand_step(input logic [LED_W-1:0] p, input logic d);
      return d ? {1'b0, p[15:9], p[6:0], 1'b0} : {p[14:8], 2'b11, p[7:1]};
   endfunction

endpackage

// File: rtl/led_next_pattern.sv
// Combinational predictor: given the tracked phase, the previous pattern and dir, produce the
// expected next pattern and the phase to take if it matches.
import led_pattern_pkg::*;

module led_next_pattern (
   input  phase_t            phase_i,
   input  logic [LED_W-1:0]  prev_i,
   input  logic              dir_i,
   output logic [LED_W-1:0]  exp_o,
   output phase_t            phase_nxt_o
);

   always_comb begin
      exp_o       = PAT_ZERO;
      phase_nxt_o = HUNT;
      unique case (phase_i)
         // In HUNT the only acceptable lock point is all-on.
         HUNT: begin
            exp_o       = PAT_ALL;
            phase_nxt_o = ALL_ON;
         end
         ALL_ON: begin
            exp_o       = PAT_FLASH;
            phase_nxt_o = FLASH;
         end
         FLASH: begin
            exp_o       = shift_step(prev_i, dir_i);
            phase_nxt_o = SHIFT;
         end
         SHIFT: begin
            if (prev_i == PAT_ZERO) begin
               exp_o       = PAT_SEED;
               phase_nxt_o = EXPAND;
            end else begin
               exp_o       = shift_step(prev_i, dir_i);
               phase_nxt_o = SHIFT;
            end
         end
         EXPAND: begin
            if (prev_i == PAT_ALL) begin
               exp_o       = PAT_ZERO;
               phase_nxt_o = GAP;
            end else begin
               exp_o       = expand_step(prev_i, dir_i);
               phase_nxt_o = EXPAND;
            end
         end
         GAP: begin
            exp_o       = PAT_FLASH;
            phase_nxt_o = FLASH;
         end
         default: begin
            exp_o       = PAT_ZERO;
            phase_nxt_o = HUNT;
         end
      endcase
   end

endmodule

// File: rtl/led_pattern_checker.sv
// Receive-side monitor that locks onto the LED generator sequence and flags deviations.
// Define LED_CHK_SEQCNT_EN to build the completed-sequence counter; otherwise seq_count_o is 0.
//
// state  | meaning
// HUNT   | unlocked, waiting for all-on
// ALL_ON | saw FFFF, expecting flash
// FLASH  | saw AAAA, expecting first shift
// SHIFT  | shifting pattern out, 0000 ends it
// EXPAND | growing/shrinking from the centre seed
// GAP    | blank frame before the next flash
import led_pattern_pkg::*;

module led_pattern_checker #(
   parameter int ERR_W = 8,
   parameter int SEQ_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_i,
   input  logic              dir_i,
   input  logic [LED_W-1:0]  led_i,
   input  logic              clr_err_i,
   output logic [2:0]        phase_o,
   output logic              locked_o,
   output logic              err_pulse_o,
   output logic              error_o,
   output logic [ERR_W-1:0]  err_count_o,
   output logic [SEQ_W-1:0]  seq_count_o
);

   phase_t            phase_q, phase_d;
   logic [LED_W-1:0]  exp_prev_q, exp_prev_d;
   logic              err_pulse_q, err_pulse_d;
   logic              error_q, error_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

   logic [LED_W-1:0]  exp;
   phase_t            phase_nxt;
   logic              match;

   led_next_pattern u_next (
      .phase_i     (phase_q),
      .prev_i      (exp_prev_q),
      .dir_i       (dir_i),
      .exp_o       (exp),
      .phase_nxt_o (phase_nxt)
   );

   assign match = (led_i == exp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= HUNT;
         exp_prev_q  <= PAT_ZERO;
         err_pulse_q <= 1'b0;
         error_q     <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         phase_q     <= phase_d;
         exp_prev_q  <= exp_prev_d;
         err_pulse_q <= err_pulse_d;
         error_q     <= error_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   always_comb begin
      phase_d     = phase_q;
      exp_prev_d  = exp_prev_q;
      err_pulse_d = 1'b0;
      error_d     = clr_err_i ? 1'b0 : error_q;
      err_cnt_d   = err_cnt_q;
      if (tick_i) begin
         if (match) begin
            phase_d    = phase_nxt;
            exp_prev_d = led_i;
         end else if (phase_q != HUNT) begin
            err_pulse_d = 1'b1;
            error_d     = 1'b1;
            if (!(&err_cnt_q))
               err_cnt_d = err_cnt_q + ERR_W'(1);
            // An all-on frame is itself a valid lock point, so resync without a HUNT tick.
            if (led_i == PAT_ALL) begin
               phase_d    = ALL_ON;
               exp_prev_d = led_i;
            end else begin
               phase_d = HUNT;
            end
         end
      end
   end

   always_comb begin
      phase_o     = phase_q;
      locked_o    = (phase_q != HUNT);
      err_pulse_o = err_pulse_q;
      error_o     = error_q;
      err_count_o = err_cnt_q;
   end

`ifdef LED_CHK_SEQCNT_EN
   logic [SEQ_W-1:0] seq_cnt_q, seq_cnt_d;

   always_comb begin
      seq_cnt_d = seq_cnt_q;
      if (tick_i && match && (phase_q == GAP))
         seq_cnt_d = seq_cnt_q + SEQ_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) seq_cnt_q <= '0;
      else     seq_cnt_q <= seq_cnt_d;
   end

   assign seq_count_o = seq_cnt_q;
`else
   assign seq_count_o = '0;
`endif

endmodule

// File: tb/tb_led_pattern_checker.sv
// Directed bench for led_pattern_checker: lock, full cycle, error handling, saturation, async reset.
module tb_led_pattern_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        dir;
   logic [15:0] led;
   logic        clr_err;
   logic [2:0]  phase;
   logic        locked;
   logic        err_pulse;
   logic        error;
   logic [7:0]  err_count;
   logic [7:0]  seq_count;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef LED_CHK_SEQCNT_EN
   localparam logic [7:0] SEQ_AFTER_CYCLE = 8'd1;
`else
   localparam logic [7:0] SEQ_AFTER_CYCLE = 8'd0;
`endif

   led_pattern_checker #(.ERR_W(8), .SEQ_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .dir_i       (dir),
      .led_i       (led),
      .clr_err_i   (clr_err),
      .phase_o     (phase),
      .locked_o    (locked),
      .err_pulse_o (err_pulse),
      .error_o     (error),
      .err_count_o (err_count),
      .seq_count_o (seq_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One tick; outputs are sampled on the following falling edge.
   task automatic step(input logic [15:0] v, input logic d);
      @(negedge clk);
      tick = 1'b1;
      led  = v;
      dir  = d;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic shift_to_zero(input logic [15:0] start);
      logic [15:0] p;
      p = start;
      for (int i = 0; i < 16 && p != 16'h0; i++) begin
         p = p >> 1;
         step(p, 1'b0);
      end
   endtask

   logic [15:0] grow_seq [7]  = '{16'h03C0, 16'h07E0, 16'h0FF0, 16'h1FF8, 16'h3FFC, 16'h7FFE, 16'hFFFF};
   logic [15:0] walk_seq [16] = '{16'h5555, 16'h2AAA, 16'h1555, 16'h0AAA,
                                  16'h1554, 16'h2AA8, 16'h5550, 16'hAAA0,
                                  16'h5540, 16'hAA80, 16'h5500, 16'hAA00,
                                  16'h5500, 16'h2A80, 16'h1540, 16'h0AA0};
   logic        walk_dir [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};

   initial begin
      rst = 1'b1; tick = 1'b0; dir = 1'b0; led = 16'h0; clr_err = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_phase", phase, 0);
      chk("rst_locked", locked, 0);
      chk("rst_error", error, 0);
      chk("rst_errcnt", err_count, 0);
      chk("rst_seqcnt", seq_count, 0);
      rst = 1'b0;

      step(16'h1234, 0); chk("hunt_ignore_phase", phase, 0);
      chk("hunt_ignore_err", err_count, 0);
      step(16'hFFFF, 0); chk("lock_all_on", phase, 1);
      step(16'hAAAA, 0); chk("lock_flash", phase, 2);
      step(16'h5555, 0); chk("lock_shift1", phase, 3);
      step(16'h2AAA, 0); chk("lock_shift2", phase, 3);
      chk("lock_locked", locked, 1);
      chk("lock_error", error, 0);

      shift_to_zero(16'h2AAA);
      chk("shift_zero_phase", phase, 3);
      step(16'h0180, 0); chk("seed_phase", phase, 4);
      foreach (grow_seq[i]) step(grow_seq[i], 0);
      chk("grow_phase", phase, 4);
      chk("grow_error", error, 0);
      step(16'h0000, 0); chk("gap_phase", phase, 5);
      step(16'hAAAA, 0); chk("cycle_phase", phase, 2);
      chk("cycle_seqcnt", seq_count, SEQ_AFTER_CYCLE);
      chk("cycle_error", error, 0);

      step(16'h5555, 0); chk("pre_err_phase", phase, 3);
      step(16'h1234, 0);
      chk("mm_pulse", err_pulse, 1);
      chk("mm_error", error, 1);
      chk("mm_errcnt", err_count, 1);
      chk("mm_phase", phase, 0);
      @(negedge clk);
      chk("mm_pulse_once", err_pulse, 0);
      step(16'hFFFF, 0); chk("relock_phase", phase, 1);
      chk("relock_pulse", err_pulse, 0);

      step(16'hAAAA, 0);
      foreach (walk_seq[i]) step(walk_seq[i], walk_dir[i]);
      chk("walk_errcnt", err_count, 1);
      step(16'h1540, 1);
      chk("dirflip_phase", phase, 3);
      chk("dirflip_pulse", err_pulse, 0);
      chk("dirflip_errcnt", err_count, 1);

      repeat (300) step(16'hFFFF, 0);
      chk("sat_errcnt", err_count, 255);
      chk("sat_phase", phase, 1);
      chk("sat_error", error, 1);

      @(negedge clk);
      tick = 1'b1; led = 16'hFFFF; dir = 1'b0; clr_err = 1'b1;
      @(negedge clk);
      tick = 1'b0; clr_err = 1'b0;
      chk("clr_vs_set_error", error, 1);
      chk("clr_vs_set_pulse", err_pulse, 1);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("clr_error", error, 0);
      chk("clr_keeps_cnt", err_count, 255);

      step(16'hAAAA, 0);
      shift_to_zero(16'hAAAA);
      step(16'h0180, 0); chk("exp2_phase", phase, 4);
      step(16'h03C0, 0);
      step(16'h0180, 1);
      step(16'h0000, 1);
      step(16'h0000, 1);
      step(16'h0000, 1);
      chk("shrink_phase", phase, 4);
      chk("shrink_error", error, 0);
      chk("shrink_errcnt", err_count, 255);

      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_phase", phase, 0);
      chk("arst_locked", locked, 0);
      chk("arst_pulse", err_pulse, 0);
      chk("arst_error", error, 0);
      chk("arst_errcnt", err_count, 0);
      chk("arst_seqcnt", seq_count, 0);
      @(negedge clk);
      rst = 1'b0;
      step(16'hAAAA, 0);
      chk("post_rst_hunt", phase, 0);
      chk("post_rst_noerr", error, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
